// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: writeback pass-through fields,
// FSM state encoding, queued item layout and load-width masks.
package lsu_pkg;

   localparam logic [31:0] RMASK_B = 32'h0000_00FF;
   localparam logic [31:0] RMASK_H = 32'h0000_FFFF;
   localparam logic [31:0] RMASK_W = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      SEND = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic [31:0] instruction;
      logic [4:0]  rd;
      logic [11:0] csr_rd;
      logic        reg_en;
      logic        csreg_en;
      logic [2:0]  wdOp;
      logic        ecall;
      logic        ebreak;
   } lsu_pass_t;

   // One execute-stage item as held in the working register or the buffer.
   typedef struct packed {
      logic [31:0] exu_result;
      logic [31:0] rsb;
      logic        ren;
      logic        wen;
      logic [3:0]  wmask;
      logic [31:0] rmask;
      logic        m_signed;
      lsu_pass_t   pass;
   } lsu_item_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load data path: shift the addressed lanes down, apply the width mask and
// optionally sign-extend from the top bit of that mask.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rmask_i,
   input  logic        m_signed_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;
   logic [31:0] masked;

   always_comb begin
      shifted  = rdata_i >> {addr_lo_i, 3'b000};
      masked   = shifted & rmask_i;
      result_o = masked;
      if (m_signed_i) begin
         if (rmask_i == RMASK_B) begin
            result_o = {{24{masked[7]}}, masked[7:0]};
         end else if (rmask_i == RMASK_H) begin
            result_o = {{16{masked[15]}}, masked[15:0]};
         end
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one working register plus a one-entry skid buffer,
// issuing a single aligned memory request per load or store item.
module lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_receive_valid,
   output logic        lsu_send_ready,
   input  logic [31:0] exu_result_i,
   input  logic [31:0] rsb_i,
   input  logic        ren_i,
   input  logic        wen_i,
   input  logic [7:0]  wmask_i,
   input  logic [31:0] rmask_i,
   input  logic        m_signed_i,
   input  lsu_pass_t   pass_i,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        lsu_send_valid,
   input  logic        lsu_receive_ready,
   output logic [31:0] lsu_result_o,
   output lsu_pass_t   pass_o,
   output logic [3:0]  lsu_state_o,
   output lsu_state_e  dbg_state_o
);

   // Handshakes: an item moves across a port only on a cycle where its
   // valid and ready are both high; valid never waits on ready.

   lsu_state_e  state_q;
   lsu_item_t   work_q;
   lsu_item_t   buf_q;
   logic        buf_valid_q;
   logic [31:0] result_q;

   lsu_item_t   in_item;
   lsu_item_t   item_d;
   logic        xfer;
   logic [31:0] load_result;
   logic [3:0]  lane_mask;
   logic        unused_wmask_hi;

   assign unused_wmask_hi = ^wmask_i[7:4];

   assign in_item.exu_result = exu_result_i;
   assign in_item.rsb        = rsb_i;
   assign in_item.ren        = ren_i;
   assign in_item.wen        = wen_i;
   assign in_item.wmask      = wmask_i[3:0];
   assign in_item.rmask      = rmask_i;
   assign in_item.m_signed   = m_signed_i;
   assign in_item.pass       = pass_i;

   assign xfer   = lsu_receive_valid && lsu_send_ready;
   // Ready is low whenever the buffer is full, so in IDLE the buffer and a
   // fresh transfer never compete for the working register.
   assign item_d = buf_valid_q ? buf_q : in_item;

   lsu_load_align u_load_align (
      .rdata_i    (mem_rdata),
      .addr_lo_i  (work_q.exu_result[1:0]),
      .rmask_i    (work_q.rmask),
      .m_signed_i (work_q.m_signed),
      .result_o   (load_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         if (xfer && (state_q != IDLE)) begin
            buf_q       <= in_item;
            buf_valid_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (xfer || buf_valid_q) begin
                  work_q      <= item_d;
                  result_q    <= item_d.exu_result;
                  buf_valid_q <= 1'b0;
                  state_q     <= (item_d.ren || item_d.wen) ? REQ : SEND;
               end
            end
            REQ: begin
               if (mem_req_ready) state_q <= WAIT;
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  result_q <= work_q.ren ? load_result : work_q.exu_result;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               if (lsu_receive_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lane_mask      = work_q.wmask << work_q.exu_result[1:0];

   assign lsu_send_ready = !buf_valid_q;
   assign mem_req_valid  = (state_q == REQ);
   assign mem_addr       = {work_q.exu_result[31:2], 2'b00};
   assign mem_wen        = (state_q == REQ) && work_q.wen;
   assign mem_wmask      = ((state_q == REQ) && work_q.wen) ? lane_mask : 4'b0000;
   assign mem_wdata      = work_q.rsb << {work_q.exu_result[1:0], 3'b000};
   assign lsu_send_valid = (state_q == SEND);
   assign lsu_result_o   = result_q;
   assign pass_o         = work_q.pass;
   assign lsu_state_o    = {work_q.pass.csreg_en, work_q.pass.reg_en,
                            state_q != IDLE, buf_valid_q};
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single items plus hand-written
// sequences for back-pressure, buffering and reset during a transaction.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_receive_valid;
   logic        lsu_send_ready;
   logic [31:0] exu_result_i;
   logic [31:0] rsb_i;
   logic        ren_i;
   logic        wen_i;
   logic [7:0]  wmask_i;
   logic [31:0] rmask_i;
   logic        m_signed_i;
   lsu_pass_t   pass_i;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        lsu_send_valid;
   logic        lsu_receive_ready;
   logic [31:0] lsu_result_o;
   lsu_pass_t   pass_o;
   logic [3:0]  lsu_state_o;
   lsu_state_e  dbg_state_o;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] exp_q[$];

   lsu dut (
      .clk               (clk),
      .rst               (rst),
      .lsu_receive_valid (lsu_receive_valid),
      .lsu_send_ready    (lsu_send_ready),
      .exu_result_i      (exu_result_i),
      .rsb_i             (rsb_i),
      .ren_i             (ren_i),
      .wen_i             (wen_i),
      .wmask_i           (wmask_i),
      .rmask_i           (rmask_i),
      .m_signed_i        (m_signed_i),
      .pass_i            (pass_i),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_addr          (mem_addr),
      .mem_wen           (mem_wen),
      .mem_wdata         (mem_wdata),
      .mem_wmask         (mem_wmask),
      .mem_resp_valid    (mem_resp_valid),
      .mem_rdata         (mem_rdata),
      .lsu_send_valid    (lsu_send_valid),
      .lsu_receive_ready (lsu_receive_ready),
      .lsu_result_o      (lsu_result_o),
      .pass_o            (pass_o),
      .lsu_state_o       (lsu_state_o),
      .dbg_state_o       (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic lsu_pass_t make_pass(input int idx);
      lsu_pass_t p;
      p.pc          = 32'h8000_0000 + 32'(idx * 4);
      p.pc_next     = 32'h8000_0004 + 32'(idx * 4);
      p.instruction = 32'h0000_0013 ^ 32'(idx << 7);
      p.rd          = 5'(idx + 1);
      p.csr_rd      = 12'(12'h300 + idx);
      p.reg_en      = idx[0];
      p.csreg_en    = idx[1];
      p.wdOp        = 3'(idx);
      p.ecall       = idx[2];
      p.ebreak      = idx[3];
      return p;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_item(input logic [31:0] exu, input logic [31:0] rsb,
                             input logic ren, input logic wen,
                             input logic [7:0] wmask, input logic [31:0] rmask,
                             input logic sgn, input lsu_pass_t p);
      exu_result_i      = exu;
      rsb_i             = rsb;
      ren_i             = ren;
      wen_i             = wen;
      wmask_i           = wmask;
      rmask_i           = rmask;
      m_signed_i        = sgn;
      pass_i            = p;
      lsu_receive_valid = 1'b1;
   endtask

   task automatic idle_inputs();
      lsu_receive_valid = 1'b0;
      exu_result_i      = 32'h0;
      rsb_i             = 32'h0;
      ren_i             = 1'b0;
      wen_i             = 1'b0;
      wmask_i           = 8'h0;
      rmask_i           = 32'h0;
      m_signed_i        = 1'b0;
      pass_i            = '0;
   endtask

   typedef struct {
      logic [31:0] exu;
      logic [31:0] rsb;
      logic        ren;
      logic        wen;
      logic [7:0]  wmask;
      logic [31:0] rmask;
      logic        sgn;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wmask;
      logic [31:0] exp_wdata;
      logic        chk_res;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs[11];

   initial begin
      lsu_pass_t p;
      lsu_pass_t p2;
      logic [31:0] e;

      vecs[0]  = '{32'h0000_1234, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0,
                   32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_1234};
      vecs[1]  = '{32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_B, 1'b1, 32'h80FF_FFFF,
                   32'h8000_0000, 4'h0, 32'h0, 1'b1, 32'hFFFF_FF80};
      vecs[2]  = '{32'h8000_0002, 32'h0000_ABCD, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0, 32'h0,
                   32'h8000_0000, 4'hC, 32'hABCD_0000, 1'b0, 32'h0};
      vecs[3]  = '{32'h1000_0002, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_H, 1'b0, 32'h8765_4321,
                   32'h1000_0000, 4'h0, 32'h0, 1'b1, 32'h0000_8765};
      vecs[4]  = '{32'h1000_0002, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_H, 1'b1, 32'h8765_4321,
                   32'h1000_0000, 4'h0, 32'h0, 1'b1, 32'hFFFF_8765};
      vecs[5]  = '{32'h2000_0000, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_W, 1'b1, 32'hDEAD_BEEF,
                   32'h2000_0000, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF};
      vecs[6]  = '{32'h3000_0001, 32'h1234_5678, 1'b0, 1'b1, 8'hF1, 32'h0, 1'b0, 32'h0,
                   32'h3000_0000, 4'h2, 32'h3456_7800, 1'b0, 32'h0};
      vecs[7]  = '{32'h4000_0001, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_B, 1'b0, 32'h0000_A500,
                   32'h4000_0000, 4'h0, 32'h0, 1'b1, 32'h0000_00A5};
      vecs[8]  = '{32'h4000_0001, 32'h0, 1'b1, 1'b0, 8'h00, RMASK_B, 1'b1, 32'h0000_A500,
                   32'h4000_0000, 4'h0, 32'h0, 1'b1, 32'hFFFF_FFA5};
      vecs[9]  = '{32'h8000_0003, 32'h0, 1'b0, 1'b0, 8'h0F, RMASK_B, 1'b1, 32'h0,
                   32'h0, 4'h0, 32'h0, 1'b1, 32'h8000_0003};
      vecs[10] = '{32'h5000_0003, 32'hAABB_CCDD, 1'b0, 1'b1, 8'h01, 32'h0, 1'b0, 32'h0,
                   32'h5000_0000, 4'h8, 32'hDD00_0000, 1'b0, 32'h0};

      // reset state
      rst               = 1'b1;
      mem_req_ready     = 1'b0;
      mem_resp_valid    = 1'b0;
      mem_rdata         = 32'h0;
      lsu_receive_ready = 1'b1;
      idle_inputs();
      repeat (2) tick();
      check("rst_send_ready", lsu_send_ready, 1);
      check("rst_send_valid", lsu_send_valid, 0);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wmask", mem_wmask, 0);
      check("rst_result", lsu_result_o, 0);
      check("rst_pass_o", pass_o, 0);
      check("rst_state_o", lsu_state_o, 0);
      rst = 1'b0;
      tick();

      // table-driven single items
      for (int i = 0; i < 11; i++) begin
         p = make_pass(i + 1);
         drive_item(vecs[i].exu, vecs[i].rsb, vecs[i].ren, vecs[i].wen,
                    vecs[i].wmask, vecs[i].rmask, vecs[i].sgn, p);
         tick();
         idle_inputs();
         if (vecs[i].ren || vecs[i].wen) begin
            check($sformatf("v%0d_req_valid", i), mem_req_valid, 1);
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_wen", i), mem_wen, vecs[i].wen);
            check($sformatf("v%0d_wmask", i), mem_wmask, vecs[i].exp_wmask);
            if (vecs[i].wen) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_early_send", i), lsu_send_valid, 0);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            check($sformatf("v%0d_req_drop", i), mem_req_valid, 0);
            check($sformatf("v%0d_wait_send", i), lsu_send_valid, 0);
            mem_resp_valid = 1'b1;
            mem_rdata      = vecs[i].rdata;
            tick();
            mem_resp_valid = 1'b0;
            mem_rdata      = 32'h0;
         end
         check($sformatf("v%0d_send_valid", i), lsu_send_valid, 1);
         if (vecs[i].chk_res) check($sformatf("v%0d_result", i), lsu_result_o, vecs[i].exp_res);
         check($sformatf("v%0d_pass", i), pass_o, p);
         tick();
         check($sformatf("v%0d_idle", i), lsu_send_valid, 0);
      end

      // request held off by memory, stray response ignored, then send back-pressure
      p = make_pass(20);
      drive_item(32'h5000_0004, 32'h0, 1'b1, 1'b0, 8'h0, RMASK_W, 1'b0, p);
      tick();
      idle_inputs();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold_req_valid%0d", k), mem_req_valid, 1);
         check($sformatf("hold_addr%0d", k), mem_addr, 32'h5000_0004);
         mem_resp_valid = (k == 2);
         mem_rdata      = 32'hBAD0_BAD0;
         tick();
      end
      mem_resp_valid = 1'b0;
      check("hold_still_req", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h1122_3344;
      lsu_receive_ready = 1'b0;
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp_send_valid%0d", k), lsu_send_valid, 1);
         check($sformatf("bp_result%0d", k), lsu_result_o, 32'h1122_3344);
         check($sformatf("bp_pass%0d", k), pass_o, p);
         tick();
      end
      check("bp_still_send", lsu_send_valid, 1);
      lsu_receive_ready = 1'b1;
      tick();
      check("bp_released", lsu_send_valid, 0);

      // second item arrives during WAIT and is buffered
      p  = make_pass(30);
      p2 = make_pass(31);
      drive_item(32'h6000_0000, 32'h0, 1'b1, 1'b0, 8'h0, RMASK_W, 1'b0, p);
      exp_q.push_back(32'hCAFE_0001);
      tick();
      idle_inputs();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("buf_ready_before", lsu_send_ready, 1);
      drive_item(32'h0000_0777, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, p2);
      exp_q.push_back(32'h0000_0777);
      tick();
      idle_inputs();
      check("buf_ready_low", lsu_send_ready, 0);
      check("buf_state_bit", lsu_state_o[0], 1);
      check("buf_in_wait", dbg_state_o, WAIT);
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'hCAFE_0001;
      tick();
      mem_resp_valid = 1'b0;
      e = exp_q.pop_front();
      check("buf_first_valid", lsu_send_valid, 1);
      check("buf_first_result", lsu_result_o, e);
      check("buf_first_pass", pass_o, p);
      tick();
      check("buf_gap_valid", lsu_send_valid, 0);
      check("buf_gap_ready", lsu_send_ready, 0);
      drive_item(32'h0000_0999, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, make_pass(32));
      tick();
      idle_inputs();
      e = exp_q.pop_front();
      check("buf_second_valid", lsu_send_valid, 1);
      check("buf_second_result", lsu_result_o, e);
      check("buf_second_pass", pass_o, p2);
      check("buf_drained_ready", lsu_send_ready, 1);
      check("buf_second_state", lsu_state_o, {p2.csreg_en, p2.reg_en, 1'b1, 1'b0});
      tick();
      check("drop_idle0", lsu_send_valid, 0);
      tick();
      check("drop_idle1", lsu_send_valid, 0);
      check("drop_no_req", mem_req_valid, 0);
      check("exp_q_empty", exp_q.size(), 0);

      // reset while waiting for the response
      drive_item(32'h7000_0000, 32'h0, 1'b1, 1'b0, 8'h0, RMASK_B, 1'b1, make_pass(40));
      tick();
      idle_inputs();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("rstw_in_wait", dbg_state_o, WAIT);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_idle", dbg_state_o, IDLE);
      check("rstw_ready", lsu_send_ready, 1);
      check("rstw_state_o", lsu_state_o, 0);
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_00FF;
      tick();
      mem_resp_valid = 1'b0;
      check("rstw_late_resp_state", dbg_state_o, IDLE);
      check("rstw_late_send", lsu_send_valid, 0);
      check("rstw_late_req", mem_req_valid, 0);
      check("rstw_result", lsu_result_o, 0);
      tick();
      check("rstw_still_idle", lsu_send_valid, 0);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
